// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, press/held/release FSM
// and auto-repeat generator. Emits single-cycle press/release/repeat events.
module btn_debounce #(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       pressed,
    output logic       press,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic [7:0] press_cnt
);

    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic        IDLE_LVL = ACTIVE_LOW;

    typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic [RW-1:0]   rpt_inc, rpt_target;
    logic            rpt_first_q, rpt_first_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            rpt_q, rpt_d;
    logic [7:0]      pcnt_q, pcnt_d;
    logic            s1_q, s2_q;
    logic            act;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= IDLE_LVL;
            s2_q <= IDLE_LVL;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    // act = 1 whenever the synchronized pad is at its pressed level
    assign act        = s2_q ^ ACTIVE_LOW;
    assign rpt_inc    = rpt_cnt_q + 1'b1;
    assign rpt_target = rpt_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        rpt_d       = 1'b0;
        pcnt_d      = pcnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (act) begin
                    state_d = StPressWait;
                    cnt_d   = CW'(1);
                end
            end
            StPressWait: begin
                if (!act) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d     = StHeld;
                    cnt_d       = '0;
                    press_d     = 1'b1;
                    pcnt_d      = pcnt_q + 8'd1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                // Leaving HELD freezes the repeat timer; a bounce back resumes it.
                if (!act) begin
                    state_d = StReleaseWait;
                    cnt_d   = CW'(1);
                end else if (rpt_inc == rpt_target) begin
                    rpt_d       = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b0;
                end else begin
                    rpt_cnt_d = rpt_inc;
                end
            end
            StReleaseWait: begin
                if (act) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            rpt_q       <= 1'b0;
            pcnt_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            rpt_q       <= rpt_d;
            pcnt_q      <= pcnt_d;
        end
    end

    assign pressed       = (state_q == StHeld) || (state_q == StReleaseWait);
    assign press         = press_q;
    assign release_pulse = rel_q;
    assign repeat_pulse  = rpt_q;
    assign press_cnt     = pcnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed and randomized button waveforms checked every cycle
// against a run-length reference model of the debounce and repeat rules.
module tb_btn_debounce;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       pressed;
    logic       press;
    logic       release_pulse;
    logic       repeat_pulse;
    logic [7:0] press_cnt;

    int vectors;
    int miscompares;

    // Reference model: debounced level flips once act has disagreed with it for D+1 edges.
    logic       m_s1, m_s2;
    logic       m_lvl;
    int         m_run;
    int         m_t;
    logic       m_first;
    logic [7:0] m_cnt;
    logic       m_press, m_rel, m_rpt;

    btn_debounce #(
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .pressed      (pressed),
        .press        (press),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .press_cnt    (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 1'b1;
        m_s2 = 1'b1;
        m_lvl = 1'b0;
        m_run = 0;
        m_t = 0;
        m_first = 1'b0;
        m_cnt = 8'd0;
        m_press = 1'b0;
        m_rel = 1'b0;
        m_rpt = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic act;
        logic held;
        act = ~m_s2;
        m_press = 1'b0;
        m_rel = 1'b0;
        m_rpt = 1'b0;
        held = m_lvl && (m_run == 0);
        if (act != m_lvl) m_run = m_run + 1;
        else m_run = 0;
        if (held && act) begin
            m_t = m_t + 1;
            if (m_t == (m_first ? RD : RP)) begin
                m_rpt = 1'b1;
                m_t = 0;
                m_first = 1'b0;
            end
        end
        if (m_run == D + 1) begin
            m_lvl = ~m_lvl;
            m_run = 0;
            if (m_lvl) begin
                m_press = 1'b1;
                m_cnt = m_cnt + 8'd1;
                m_t = 0;
                m_first = 1'b1;
            end else begin
                m_rel = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic check(input string tag);
        logic [11:0] obs, exp;
        obs = {pressed, press, release_pulse, repeat_pulse, press_cnt};
        exp = {m_lvl, m_press, m_rel, m_rpt, m_cnt};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic b, input string tag);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
        check(tag);
    endtask

    task automatic steps(input int n, input logic b, input string tag);
        for (int i = 0; i < n; i++) step(b, tag);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic mid_reset(input int n, input logic b);
        #2;
        rst = 1'b0;
        btn_in = b;
        #1;
        model_reset();
        check("async_rst");
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("in_rst");
        end
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int         lat;
        logic       found;
        logic [7:0] cnt_start;
        logic       lvl;
        int         len;

        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        btn_in = 1'b1;
        model_reset();
        #2;
        check("reset");
        #10;
        rst = 1'b1;

        steps(5, 1'b1, "idle");

        // Clean press: press must appear after the 7th sampled edge (edge 0 .. edge 6).
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, "clean_press");
            lat++;
            if (press) found = 1'b1;
        end
        vectors++;
        assert (found && lat == 7)
        else begin
            miscompares++;
            $error("FAIL press_latency obs=%0d exp=7 found=%0d", lat, found);
        end
        steps(30, 1'b0, "long_hold");
        steps(12, 1'b1, "clean_release");

        // Bounce shorter than the debounce window must not register.
        cnt_start = m_cnt;
        steps(3, 1'b0, "bounce");
        steps(1, 1'b1, "bounce");
        steps(3, 1'b0, "bounce");
        steps(10, 1'b1, "bounce");
        vectors++;
        assert (press_cnt === cnt_start && pressed === 1'b0)
        else begin
            miscompares++;
            $error("FAIL bounce_reject obs=%h/%b exp=%h/0", press_cnt, pressed, cnt_start);
        end

        // Release with bounce, then a glitch inside the release window resuming HELD.
        steps(9, 1'b0, "press2");
        steps(2, 1'b1, "rel_bounce");
        steps(1, 1'b0, "rel_bounce");
        steps(10, 1'b1, "rel_bounce");
        steps(12, 1'b0, "press3");
        steps(3, 1'b1, "rw_glitch");
        steps(20, 1'b0, "rw_glitch");
        steps(10, 1'b1, "rw_glitch");

        // Reset mid-hold with the button still down, then re-press after reset.
        steps(15, 1'b0, "pre_rst");
        mid_reset(3, 1'b0);
        steps(20, 1'b0, "post_rst");
        steps(10, 1'b1, "post_rst");

        // Reset mid-release window.
        steps(10, 1'b0, "pre_rst2");
        steps(3, 1'b1, "pre_rst2");
        mid_reset(2, 1'b1);
        steps(6, 1'b1, "post_rst2");

        for (int r = 0; r < 150; r++) begin
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(10, 40);
            else len = $urandom_range(1, 6);
            steps(len, lvl, "random");
        end
        steps(10, 1'b1, "settle");

        // 256 clean presses wrap the counter back to its starting value.
        cnt_start = m_cnt;
        for (int k = 0; k < 256; k++) begin
            steps(8, 1'b0, "wrap");
            steps(8, 1'b1, "wrap");
        end
        vectors++;
        assert (press_cnt === cnt_start)
        else begin
            miscompares++;
            $error("FAIL wrap obs=%h exp=%h", press_cnt, cnt_start);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
